// File: rtl/uart_feed_pkg.sv
//==============================================================================
// Module      : uart_feed_pkg
// Description : Shared types and helpers for the UART block feeder.
//               - feed_state_t    : sequencer state encoding
//               - CHAR_CR/CHAR_LF : line terminator characters (hex mode)
//               - nibble_to_ascii : 4-bit value -> uppercase ASCII hex digit
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_feed_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        ACK   = 3'd2,
        DRAIN = 3'd3,
        NEXT  = 3'd4
    } feed_state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // 0-9 map onto '0'..'9' (8'h30..8'h39); A-F map onto 'A'..'F' (8'h41..8'h46).
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_block_feeder.sv
//==============================================================================
// Module      : uart_block_feeder
// Description : Accepts one NBYTES-wide block per valid/ready handshake and
//               feeds it, byte 0 first, to a UART transmitter through its
//               START/DATA/BUSY interface, one character at a time.
//               Build option UART_FEED_HEX_EN: each byte is rendered as two
//               uppercase ASCII hex digits (high nibble first), followed by
//               CR LF. Without it, bytes are sent raw with no terminator.
// Ports       : CLK       - system clock
//               RST       - synchronous active-high reset
//               IN_DATA   - block; byte k = IN_DATA[8k+7:8k]
//               IN_VALID  - block available
//               IN_READY  - feeder idle, can accept a block
//               TX_START  - one-cycle start pulse to the transmitter
//               TX_DATA   - character, held until the next TX_START
//               TX_BUSY   - transmitter busy
//               ACTIVE    - block in progress
//               ERR       - sticky ACK-timeout flag, cleared only by RST
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_block_feeder
    import uart_feed_pkg::*;
#(
    parameter int NBYTES      = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [8*NBYTES-1:0]   IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic                  TX_START,
    output logic [7:0]            TX_DATA,
    input  logic                  TX_BUSY,
    output logic                  ACTIVE,
    output logic                  ERR
);

`ifdef UART_FEED_HEX_EN
    localparam int NCHARS = 2 * NBYTES + 2;
`else
    localparam int NCHARS = NBYTES;
`endif
    localparam int IDX_W = $clog2(NCHARS + 1);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    feed_state_t          r_state;
    feed_state_t          w_state_nxt;
    logic [8*NBYTES-1:0]  r_buf;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_ack_cnt;
    logic                 r_tx_start;
    logic [7:0]           r_tx_data;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_issue;
    logic                 w_ack_timeout;
    logic                 w_last;
    logic [IDX_W-1:0]     w_byte_sel;
    logic [7:0]           w_byte;
    logic [7:0]           w_char;

    //--------------------------------------------------------------------------
    // Control strobes
    //--------------------------------------------------------------------------
    always_comb begin
        w_accept      = (r_state == IDLE) && IN_VALID;
        w_issue       = (r_state == ISSUE) && !TX_BUSY;
        w_ack_timeout = (r_state == ACK) && !TX_BUSY &&
                        (r_ack_cnt == CNT_W'(ACK_TIMEOUT));
        w_last        = (r_idx == IDX_W'(NCHARS - 1));
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_issue) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                if (TX_BUSY) begin
                    w_state_nxt = DRAIN;
                end else if (w_ack_timeout) begin
                    // Transmitter never acknowledged: count the character as
                    // sent so the block still completes.
                    w_state_nxt = NEXT;
                end
            end
            DRAIN: begin
                if (!TX_BUSY) begin
                    w_state_nxt = NEXT;
                end
            end
            NEXT: begin
                w_state_nxt = w_last ? IDLE : ISSUE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Character selection: mux over the block buffer by character index
    //--------------------------------------------------------------------------
`ifdef UART_FEED_HEX_EN
    assign w_byte_sel = r_idx >> 1;
`else
    assign w_byte_sel = r_idx;
`endif

    always_comb begin
        w_byte = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            if (int'(w_byte_sel) == k) begin
                w_byte = r_buf[8*k +: 8];
            end
        end
    end

    always_comb begin
`ifdef UART_FEED_HEX_EN
        if (int'(r_idx) == 2 * NBYTES) begin
            w_char = CHAR_CR;
        end else if (int'(r_idx) == 2 * NBYTES + 1) begin
            w_char = CHAR_LF;
        end else begin
            // Even index carries the high nibble so each byte reads naturally.
            w_char = nibble_to_ascii(r_idx[0] ? w_byte[3:0] : w_byte[7:4]);
        end
`else
        w_char = w_byte;
`endif
    end

    //--------------------------------------------------------------------------
    // State and datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_buf      <= '0;
            r_idx      <= '0;
            r_ack_cnt  <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_start <= w_issue;

            if (w_accept) begin
                r_buf <= IN_DATA;
                r_idx <= '0;
            end

            if (w_issue) begin
                // TX_DATA changes only here, so it stays stable across the
                // whole frame and until the next start pulse.
                r_tx_data <= w_char;
                r_ack_cnt <= CNT_W'(1);
            end else if ((r_state == ACK) && !TX_BUSY && !w_ack_timeout) begin
                r_ack_cnt <= r_ack_cnt + CNT_W'(1);
            end

            if (w_ack_timeout) begin
                r_err <= 1'b1;
            end

            if (r_state == NEXT) begin
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    assign IN_READY = (r_state == IDLE);
    assign ACTIVE   = (r_state != IDLE);
    assign TX_START = r_tx_start;
    assign TX_DATA  = r_tx_data;
    assign ERR      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_block_feeder.sv
//==============================================================================
// Module      : tb_uart_block_feeder
// Description : Self-checking bench for uart_block_feeder (NBYTES=8,
//               ACK_TIMEOUT=15) with a transmitter model whose BUSY rises one
//               cycle after START and stays high for 40 cycles. Follows the
//               UART_FEED_HEX_EN build option of the design.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_block_feeder;

    localparam int NBYTES      = 8;
    localparam int ACK_TIMEOUT = 15;
`ifdef UART_FEED_HEX_EN
    localparam int NCHARS = 2 * NBYTES + 2;
`else
    localparam int NCHARS = NBYTES;
`endif

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic [8*NBYTES-1:0]  IN_DATA = '0;
    logic                 IN_VALID = 1'b0;
    logic                 IN_READY;
    logic                 TX_START;
    logic [7:0]           TX_DATA;
    logic                 TX_BUSY;
    logic                 ACTIVE;
    logic                 ERR;

    int checks = 0;
    int errors = 0;

    // Transmitter model plus override used for the stuck-low / stuck-high cases
    logic [5:0] r_bcnt = '0;
    logic       busy_ovr_en  = 1'b0;
    logic       busy_ovr_val = 1'b0;
    assign TX_BUSY = busy_ovr_en ? busy_ovr_val : (r_bcnt != 6'd0);

    always @(posedge CLK) begin
        if (TX_START)           r_bcnt <= 6'd40;
        else if (r_bcnt != 6'd0) r_bcnt <= r_bcnt - 6'd1;
    end

    always #5 CLK = ~CLK;

    uart_block_feeder #(.NBYTES(NBYTES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .TX_START (TX_START),
        .TX_DATA  (TX_DATA),
        .TX_BUSY  (TX_BUSY),
        .ACTIVE   (ACTIVE),
        .ERR      (ERR)
    );

    // Expected character i of a block, straight from the character rules
    function automatic logic [7:0] exp_char(input logic [63:0] blk, input int i);
        logic [7:0] b;
        logic [3:0] n;
`ifdef UART_FEED_HEX_EN
        if (i == 2 * NBYTES)     return 8'h0D;
        if (i == 2 * NBYTES + 1) return 8'h0A;
        b = blk[8*(i/2) +: 8];
        n = (i % 2 == 0) ? b[7:4] : b[3:0];
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
`else
        b = blk[8*i +: 8];
        n = 4'h0;
        return b | {4'h0, n};
`endif
    endfunction

    //--------------------------------------------------------------------------
    // Scoreboard / protocol monitor
    //--------------------------------------------------------------------------
    logic [7:0] exp_q[$];
    logic [7:0] seen_q[$];
    int         start_cnt = 0;
    int         cyc = 0;
    int         last_start_cyc = 0;
    logic       prev_start = 1'b0;
    logic       rst_d = 1'b1;
    logic [7:0] last_data = 8'h00;

    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_d <= RST;
    end

    always @(negedge CLK) begin
        logic [7:0] e;
        if (TX_START) begin
            start_cnt++;
            last_start_cyc = cyc;
            seen_q.push_back(TX_DATA);
            checks++;
            if (TX_BUSY) begin
                errors++;
                $display("FAIL start_while_busy: TX_BUSY=%0b at TX_START, required 0", TX_BUSY);
            end
            checks++;
            if (prev_start) begin
                errors++;
                $display("FAIL start_consecutive: TX_START high two cycles in a row, required single pulse");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_start: TX_DATA=%02h with no character expected", TX_DATA);
            end else begin
                e = exp_q.pop_front();
                if (TX_DATA !== e) begin
                    errors++;
                    $display("FAIL tx_data: got %02h, required %02h", TX_DATA, e);
                end
            end
            last_data = TX_DATA;
        end else if (!RST && !rst_d) begin
            checks++;
            if (TX_DATA !== last_data) begin
                errors++;
                $display("FAIL tx_data_stable: got %02h, required %02h", TX_DATA, last_data);
            end
        end
        if (RST || rst_d) last_data = TX_DATA;
        prev_start = TX_START;
    end

    //--------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    //--------------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_block(input logic [63:0] blk, output int pending, output int waited);
        IN_DATA  = blk;
        IN_VALID = 1'b1;
        waited   = 0;
        while (!IN_READY && waited < 5000) begin
            tick();
            waited++;
        end
        checks++;
        if (!IN_READY) begin
            errors++;
            $display("FAIL handshake_timeout: IN_READY=%0b after %0d cycles, required 1", IN_READY, waited);
        end
        pending = exp_q.size();
        for (int i = 0; i < NCHARS; i++) exp_q.push_back(exp_char(blk, i));
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((ACTIVE || exp_q.size() != 0 || TX_BUSY) && n < 5000) begin
            tick();
            n++;
        end
        checks++;
        if (ACTIVE || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_idle_timeout: ACTIVE=%0b pending=%0d, required 0/0", name, ACTIVE, exp_q.size());
        end
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready: got %0b, required 1", name, IN_READY);
        end
    endtask

    task automatic wait_starts(input int target);
        int n = 0;
        while (start_cnt < target && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (start_cnt < target) begin
            errors++;
            $display("FAIL start_wait_timeout: starts=%0d, required %0d", start_cnt, target);
        end
    endtask

    //--------------------------------------------------------------------------
    // Scenarios
    //--------------------------------------------------------------------------
    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, required 1", IN_READY); end
        checks++; if (TX_START !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %0b, required 0", TX_START); end
        checks++; if (TX_DATA !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h, required 00", TX_DATA); end
        checks++; if (ACTIVE !== 1'b0)   begin errors++; $display("FAIL reset_active: got %0b, required 0", ACTIVE); end
        checks++; if (ERR !== 1'b0)      begin errors++; $display("FAIL reset_err: got %0b, required 0", ERR); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_main_block();
        logic [7:0] ref_seq [NCHARS];
        int base, s0, pend, w;
`ifdef UART_FEED_HEX_EN
        ref_seq = '{8'h45, 8'h46, 8'h43, 8'h44, 8'h41, 8'h42, 8'h38, 8'h39, 8'h36,
                    8'h37, 8'h34, 8'h35, 8'h32, 8'h33, 8'h30, 8'h31, 8'h0D, 8'h0A};
`else
        ref_seq = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
`endif
        base = start_cnt;
        s0   = seen_q.size();
        send_block(64'h0123456789ABCDEF, pend, w);
        checks++;
        if (IN_READY !== 1'b0 || ACTIVE !== 1'b1) begin
            errors++;
            $display("FAIL main_busy_flags: IN_READY=%0b ACTIVE=%0b, required 0/1", IN_READY, ACTIVE);
        end
        wait_idle("main");
        checks++;
        if (start_cnt - base !== NCHARS) begin
            errors++;
            $display("FAIL main_start_count: got %0d, required %0d", start_cnt - base, NCHARS);
        end
        for (int i = 0; i < NCHARS; i++) begin
            checks++;
            if (seen_q.size() <= s0 + i) begin
                errors++;
                $display("FAIL main_seq_missing: char %0d not sent", i);
            end else if (seen_q[s0 + i] !== ref_seq[i]) begin
                errors++;
                $display("FAIL main_seq: char %0d got %02h, required %02h", i, seen_q[s0 + i], ref_seq[i]);
            end
        end
        checks++;
        if (ERR !== 1'b0) begin errors++; $display("FAIL main_err: got %0b, required 0", ERR); end
    endtask

    task automatic test_back_to_back();
        int base, pend, w;
        base = start_cnt;
        send_block(64'hFEDCBA9876543210, pend, w);
        send_block(64'h00FF55AA13579BDF, pend, w);
        checks++;
        if (pend !== 0) begin
            errors++;
            $display("FAIL b2b_early_accept: %0d chars of first block pending at handshake, required 0", pend);
        end
        wait_idle("b2b");
        checks++;
        if (start_cnt - base !== 2 * NCHARS) begin
            errors++;
            $display("FAIL b2b_start_count: got %0d, required %0d", start_cnt - base, 2 * NCHARS);
        end
    endtask

    task automatic test_ignore_valid();
        int pend, w;
        send_block(64'h1122334455667788, pend, w);
        repeat (20) tick();
        // Different block offered while the first is still in flight
        send_block(64'h99AABBCCDDEEFF00, pend, w);
        checks++;
        if (pend !== 0 || w == 0) begin
            errors++;
            $display("FAIL ignore_valid: pending=%0d waited=%0d at handshake, required 0 and >0", pend, w);
        end
        wait_idle("ignore");
    endtask

    task automatic test_timeout();
        int base, t1, pend, w;
        busy_ovr_en  = 1'b1;
        busy_ovr_val = 1'b0;
        base = start_cnt;
        send_block(64'h0123456789ABCDEF, pend, w);
        wait_starts(base + 1);
        t1 = last_start_cyc;
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL timeout_err_early: got %0b, required 0", ERR); end
        repeat (13) tick();
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL timeout_err_before: got %0b, required 0", ERR); end
        tick();
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL timeout_err_set: got %0b, required 1", ERR); end
        wait_starts(base + 2);
        checks++;
        if (last_start_cyc - t1 !== ACK_TIMEOUT + 2) begin
            errors++;
            $display("FAIL timeout_spacing: got %0d cycles, required %0d", last_start_cyc - t1, ACK_TIMEOUT + 2);
        end
        wait_idle("timeout");
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky: got %0b, required 1", ERR); end
        busy_ovr_en = 1'b0;
    endtask

    task automatic test_reset_mid_block();
        int base, n, pend, w;
        base = start_cnt;
        send_block(64'hA5A5A5A5DEADBEEF, pend, w);
        wait_starts(base + 3);
        n = 0;
        while (!TX_BUSY && n < 10) begin tick(); n++; end
        RST = 1'b1;
        tick();
        checks++; if (ACTIVE !== 1'b0) begin errors++; $display("FAIL rst_mid_active: got %0b, required 0", ACTIVE); end
        checks++; if (ERR !== 1'b0)    begin errors++; $display("FAIL rst_mid_err: got %0b, required 0", ERR); end
        RST = 1'b0;
        exp_q.delete();
        base = start_cnt;
        send_block(64'h0F1E2D3C4B5A6978, pend, w);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL rst_mid_ready: waited %0d cycles for IN_READY, required 0", w);
        end
        wait_idle("rst_mid");
        checks++;
        if (start_cnt - base !== NCHARS) begin
            errors++;
            $display("FAIL rst_mid_start_count: got %0d, required %0d", start_cnt - base, NCHARS);
        end
    endtask

    initial begin
        test_reset();
        test_main_block();
        test_back_to_back();
        test_ignore_valid();
        test_timeout();
        test_reset_mid_block();
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete, required finish");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
